// File: rtl/hit_judge.sv
// Per-frame collision judge: player bullets vs enemies, then optionally player body vs enemies.
// Optional feature macro: HIT_BODY_EN enables the BODY state and the eli_me output.
module hit_judge #(
  parameter int BLT_W = 10,
  parameter int BLT_H = 10,
  parameter int EN_W  = 40,
  parameter int EN_H  = 30,
  parameter int ME_W  = 40,
  parameter int ME_H  = 40
) (
  input  logic         clk_main,
  input  logic         rst,
  input  logic         en,
  input  logic         frame_tick,
  input  logic [12:0]  me_blt_vi,
  input  logic [116:0] me_blt_x,
  input  logic [116:0] me_blt_y,
  input  logic [7:0]   enemy_vi,
  input  logic [71:0]  enemy_x,
  input  logic [71:0]  enemy_y,
  input  logic         me_vi,
  input  logic [8:0]   me_x,
  input  logic [8:0]   me_y,
  output logic [12:0]  eli_me_blt,
  output logic [7:0]   eli_enemy,
  output logic         eli_me,
  output logic [15:0]  score,
  output logic         busy,
  output logic         done
);

  // state  | meaning
  // IDLE   | waiting for a frame_tick rising edge with en=1
  // SCAN   | one bullet slot per cycle, slots 0..12
  // BODY   | player body vs remaining enemies (HIT_BODY_EN only)
  // REPORT | accumulators presented on eli_* for one cycle with done
`ifdef HIT_BODY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, BODY = 2'd2, REPORT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, REPORT = 2'd3} state_t;
`endif

  localparam logic [9:0] P_BW = 10'(BLT_W);
  localparam logic [9:0] P_BH = 10'(BLT_H);
  localparam logic [9:0] P_EW = 10'(EN_W);
  localparam logic [9:0] P_EH = 10'(EN_H);

  function automatic logic f_ov(input logic [8:0] ax, input logic [8:0] ay,
                                input logic [9:0] aw, input logic [9:0] ah,
                                input logic [8:0] bx, input logic [8:0] by,
                                input logic [9:0] bw, input logic [9:0] bh);
    logic [9:0] axe, aye, bxe, bye;
    axe = {1'b0, ax};
    aye = {1'b0, ay};
    bxe = {1'b0, bx};
    bye = {1'b0, by};
    return (axe < bxe + bw) && (bxe < axe + aw) && (aye < bye + bh) && (bye < aye + ah);
  endfunction

  state_t      r_state, w_state_nxt;
  logic        r_ft, r_ft_q, r_en_q;
  logic [3:0]  r_idx;
  logic [12:0] r_hit_blt;
  logic [7:0]  r_hit_en;
  logic [15:0] r_score, w_score_nxt;
  logic [16:0] w_score_sum;
  logic [8:0]  w_bx, w_by;
  logic [7:0]  w_ov_blt, w_first;
  logic        w_ft_rise, w_rep;

  assign w_ft_rise = r_ft & ~r_ft_q;
  assign w_rep     = (r_state == REPORT) && en;
  assign w_bx      = me_blt_x[r_idx*9 +: 9];
  assign w_by      = me_blt_y[r_idx*9 +: 9];

  always_comb begin
    w_ov_blt = '0;
    for (int k = 0; k < 8; k++) begin
      w_ov_blt[k] = enemy_vi[k] & ~r_hit_en[k] &
                    f_ov(w_bx, w_by, P_BW, P_BH, enemy_x[k*9 +: 9], enemy_y[k*9 +: 9], P_EW, P_EH);
    end
  end

  // isolate the lowest-index candidate so one bullet removes at most one enemy
  assign w_first = w_ov_blt & (~w_ov_blt + 8'd1);

`ifdef HIT_BODY_EN
  localparam logic [9:0] P_MW = 10'(ME_W);
  localparam logic [9:0] P_MH = 10'(ME_H);
  logic [7:0] w_ov_me;
  logic       r_hit_me;

  always_comb begin
    w_ov_me = '0;
    for (int k = 0; k < 8; k++) begin
      w_ov_me[k] = enemy_vi[k] & ~r_hit_en[k] &
                   f_ov(me_x, me_y, P_MW, P_MH, enemy_x[k*9 +: 9], enemy_y[k*9 +: 9], P_EW, P_EH);
    end
  end

  always_ff @(posedge clk_main or posedge rst) begin
    if (rst)                                 r_hit_me <= 1'b0;
    else if (r_state == IDLE || !en)         r_hit_me <= 1'b0;
    else if (r_state == BODY)                r_hit_me <= me_vi & (|w_ov_me);
  end

  assign eli_me = w_rep ? r_hit_me : 1'b0;
`else
  localparam int lp_unused_me = ME_W + ME_H;
  logic w_unused_me;
  assign w_unused_me = ^{me_vi, me_x, me_y};
  assign eli_me      = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_ft_rise) w_state_nxt = SCAN;
`ifdef HIT_BODY_EN
        SCAN:    if (r_idx == 4'd12) w_state_nxt = BODY;
        BODY:    w_state_nxt = REPORT;
`else
        SCAN:    if (r_idx == 4'd12) w_state_nxt = REPORT;
`endif
        REPORT:  w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_main or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ft    <= 1'b0;
      r_ft_q  <= 1'b0;
      r_en_q  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ft    <= frame_tick;
      r_ft_q  <= r_ft;
      r_en_q  <= en;
    end
  end

  always_ff @(posedge clk_main or posedge rst) begin
    if (rst) begin
      r_idx     <= '0;
      r_hit_blt <= '0;
      r_hit_en  <= '0;
    end else if (r_state == IDLE || !en) begin
      r_idx     <= '0;
      r_hit_blt <= '0;
      r_hit_en  <= '0;
    end else if (r_state == SCAN) begin
      r_idx <= r_idx + 4'd1;
      if (me_blt_vi[r_idx] && (|w_ov_blt)) begin
        r_hit_blt[r_idx] <= 1'b1;
        r_hit_en         <= r_hit_en | w_first;
      end
    end
  end

  assign w_score_sum = {1'b0, r_score} + 17'($countones(r_hit_en));

  always_comb begin
    w_score_nxt = r_score;
    if (en && !r_en_q)  w_score_nxt = '0;
    else if (w_rep)     w_score_nxt = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
  end

  always_ff @(posedge clk_main or posedge rst) begin
    if (rst) r_score <= '0;
    else     r_score <= w_score_nxt;
  end

  assign score      = r_score;
  assign busy       = (r_state != IDLE);
  assign done       = w_rep;
  assign eli_me_blt = w_rep ? r_hit_blt : 13'd0;
  assign eli_enemy  = w_rep ? r_hit_en  : 8'd0;

endmodule
